// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default
// timing constants and a constant helper used to size the internal counter.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_GAP      = 3'd4,
        ST_RUN      = 3'd5,
        ST_DBG_HOLD = 3'd6
    } rst_seq_state_e;

    localparam int unsigned HOLD_CYCLES_DEF   = 16;
    localparam int unsigned GAP_CYCLES_DEF    = 8;
    localparam int unsigned READY_TIMEOUT_DEF = 1024;

    // Largest of three values; sizes the shared hold/gap/timeout counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer bank for asynchronous level inputs.
// Ports: i_clk (clock), i_rst (sync active-high reset, clears both stages),
//        i_d [W-1:0] (async inputs), o_q [W-1:0] (synchronized outputs).
module rst_seq_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: after PLL lock, holds all domains in reset, then
// releases them one by one with a gap, optionally waiting on per-domain ready
// (with timeout). In RUN a debug reset request re-resets the DBG_MASK domains.
// Losing lock drops every domain back into reset.
// Ports: i_clk, i_rst (sync active-high), i_pll_lock, i_dmireset (level),
//        i_ready[CH_NUM] -> o_nrst[CH_NUM] (active-low resets), o_done,
//        o_timeout[CH_NUM] (sticky, cleared only by i_rst).
// Build option: define RST_SEQ_SYNC_EN to pass i_pll_lock, i_dmireset and
// i_ready through 2-flop synchronizers (+2 cycles on every input response).
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned        CH_NUM        = 4,
    parameter int unsigned        HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned        GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int unsigned        READY_TIMEOUT = READY_TIMEOUT_DEF,
    parameter logic [CH_NUM-1:0]  READY_MASK    = '0,
    parameter logic [CH_NUM-1:0]  DBG_MASK      = '1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pll_lock,
    input  logic              i_dmireset,
    input  logic [CH_NUM-1:0] i_ready,
    output logic [CH_NUM-1:0] o_nrst,
    output logic              o_done,
    output logic [CH_NUM-1:0] o_timeout
);

    localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, READY_TIMEOUT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned KW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CH_NUM - 1);

    logic              w_lock;
    logic              w_dmi;
    logic [CH_NUM-1:0] w_ready;

    rst_seq_state_e    r_state;
    logic [KW-1:0]     r_k;
    logic [CNT_W-1:0]  r_cnt;

`ifdef RST_SEQ_SYNC_EN
    logic [CH_NUM+1:0] w_sync_q;

    rst_seq_sync2 #(
        .W (CH_NUM + 2)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({i_pll_lock, i_dmireset, i_ready}),
        .o_q   (w_sync_q)
    );

    assign w_lock  = w_sync_q[CH_NUM+1];
    assign w_dmi   = w_sync_q[CH_NUM];
    assign w_ready = w_sync_q[CH_NUM-1:0];
`else
    assign w_lock  = i_pll_lock;
    assign w_dmi   = i_dmireset;
    assign w_ready = i_ready;
`endif

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_cnt     <= '0;
            o_nrst    <= '0;
            o_done    <= 1'b0;
            o_timeout <= '0;
        end else if (r_state != ST_IDLE && !w_lock) begin
            // Lock loss beats everything else, including a debug request.
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            o_nrst  <= '0;
            o_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_nrst <= '0;
                    o_done <= 1'b0;
                    r_k    <= '0;
                    r_cnt  <= '0;
                    if (w_lock) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_k     <= '0;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // A gated domain whose ready is already up skips the wait.
                    o_nrst[r_k] <= 1'b1;
                    r_cnt       <= '0;
                    if (READY_MASK[r_k] && !w_ready[r_k]) begin
                        r_state <= ST_WAIT_RDY;
                    end else if (r_k == K_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                ST_WAIT_RDY: begin
                    if (w_ready[r_k]) begin
                        r_cnt   <= '0;
                        r_state <= (r_k == K_LAST) ? ST_RUN : ST_GAP;
                    end else if (r_cnt == CNT_W'(READY_TIMEOUT - 1)) begin
                        o_timeout[r_k] <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= (r_k == K_LAST) ? ST_RUN : ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // The last domain goes straight to RUN, so GAP always advances k.
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_k     <= r_k + KW'(1);
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    o_done <= 1'b1;
                    o_nrst <= '1;
                    if (w_dmi) begin
                        o_nrst  <= ~DBG_MASK;
                        o_done  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_DBG_HOLD;
                    end
                end
                ST_DBG_HOLD: begin
                    // Counter saturates at the hold length while the request stays high.
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        if (!w_dmi) begin
                            o_nrst  <= '1;
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
